vga_scan_ctrl: RTL and testbench

VGA raster initiator that drives the sprite pixel-query interface: it generates `xvga`/`yvga` pixel coordinates and samples the returned 3-bit `color`.
- Produces 640x480@60 timing from a 50 MHz `clk` (25 MHz pixel rate via divide-by-2).
- Exposes a 320x240 logical grid, so each logical pixel is 2x2 physical pixels.
- Delays sync/blank to match the sprite's registered colour latency and drives the board DAC pins.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing, logical-grid and colour constants for the scan controller.
// Also holds the stage-0 timing bundle that travels down the alignment pipeline.
package vga_pkg;

   localparam int H_VISIBLE      = 640;
   localparam int H_FP           = 16;
   localparam int H_SYNC         = 96;
   localparam int H_BP           = 48;
   localparam int H_TOTAL        = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_VISIBLE      = 480;
   localparam int V_FP           = 10;
   localparam int V_SYNC         = 2;
   localparam int V_BP           = 33;
   localparam int V_TOTAL        = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int SPRITE_LATENCY = 1;

   localparam int LOG_W = 320;
   localparam int LOG_H = 240;
   localparam int X_W   = $clog2(LOG_W);
   localparam int Y_W   = $clog2(LOG_H);
   localparam int CNT_W = 10;

   localparam int R_BIT = 2;
   localparam int G_BIT = 1;
   localparam int B_BIT = 0;

   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
   } timing_t;

   localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

   function automatic logic [7:0] expand_bit(input logic b);
      return {8{b}};
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline; every stage is visible so callers can tap
// intermediate delays. All stages load RESET_VAL on reset.
module vga_delay_line #(
   parameter int               DEPTH     = 2,
   parameter int               WIDTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH-1:0]            din,
   output logic [DEPTH-1:0][WIDTH-1:0] taps
);

   // shift register: taps[i] is din delayed by i+1 clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taps <= {DEPTH{RESET_VAL}};
      end else begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster initiator: 2x2-scaled coordinates for the sprite, sync/blank
// delayed to line up with the sprite's registered colour, DAC pin drive.
module vga_scan_ctrl #(
   parameter int H_VISIBLE      = vga_pkg::H_VISIBLE,
   parameter int H_FP           = vga_pkg::H_FP,
   parameter int H_SYNC         = vga_pkg::H_SYNC,
   parameter int H_BP           = vga_pkg::H_BP,
   parameter int V_VISIBLE      = vga_pkg::V_VISIBLE,
   parameter int V_FP           = vga_pkg::V_FP,
   parameter int V_SYNC         = vga_pkg::V_SYNC,
   parameter int V_BP           = vga_pkg::V_BP,
   parameter int SPRITE_LATENCY = vga_pkg::SPRITE_LATENCY
) (
   input  logic                    clk,
   input  logic                    resetn,
   output logic [vga_pkg::X_W-1:0] xvga,
   output logic [vga_pkg::Y_W-1:0] yvga,
   input  logic [2:0]              color,
   output logic [7:0]              vga_r,
   output logic [7:0]              vga_g,
   output logic [7:0]              vga_b,
   output logic                    vga_hs,
   output logic                    vga_vs,
   output logic                    vga_blank_n,
   output logic                    vga_sync_n,
   output logic                    vga_clk,
   output logic                    frame_start
);

   import vga_pkg::*;

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int D        = SPRITE_LATENCY + 1;
   // colour is gated by vis one stage earlier than the pins, since RGB adds a register
   localparam int MID      = (D >= 2) ? D - 2 : 0;

   logic                          pix_en_r;
   logic [CNT_W-1:0]              hcount_r;
   logic [CNT_W-1:0]              vcount_r;
   logic                          hwrap_s;
   logic                          vwrap_s;
   timing_t                       stage0_s;
   logic [D-1:0][$bits(timing_t)-1:0] taps_s;
   timing_t                       mid_s;
   timing_t                       out_s;
   logic [7:0]                    r_r;
   logic [7:0]                    g_r;
   logic [7:0]                    b_r;
   logic                          frame_start_r;

   assign hwrap_s = (hcount_r == CNT_W'(H_TOTAL - 1));
   assign vwrap_s = (vcount_r == CNT_W'(V_TOTAL - 1));

   // pixel enable: divide-by-2 of clk, starts low after reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_en_r <= 1'b0;
      end else begin
         pix_en_r <= ~pix_en_r;
      end
   end

   // raster counters, one step per pixel
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hcount_r <= '0;
         vcount_r <= '0;
      end else if (pix_en_r) begin
         if (hwrap_s) begin
            hcount_r <= '0;
            vcount_r <= vwrap_s ? '0 : vcount_r + CNT_W'(1);
         end else begin
            hcount_r <= hcount_r + CNT_W'(1);
         end
      end
   end

   // stage-0 timing and logical coordinates straight from the counters
   always_comb begin
      stage0_s.vis = (hcount_r < CNT_W'(H_VISIBLE)) && (vcount_r < CNT_W'(V_VISIBLE));
      stage0_s.hs  = !((hcount_r >= CNT_W'(HS_START)) && (hcount_r < CNT_W'(HS_END)));
      stage0_s.vs  = !((vcount_r >= CNT_W'(VS_START)) && (vcount_r < CNT_W'(VS_END)));
      if (stage0_s.vis) begin
         xvga = hcount_r[X_W:1];
         yvga = vcount_r[Y_W:1];
      end else begin
         xvga = '0;
         yvga = '0;
      end
   end

   vga_delay_line #(
      .DEPTH     (D),
      .WIDTH     ($bits(timing_t)),
      .RESET_VAL (TIMING_IDLE)
   ) u_align (
      .clk   (clk),
      .rst_n (resetn),
      .din   (stage0_s),
      .taps  (taps_s)
   );

   assign mid_s = timing_t'(taps_s[MID]);
   assign out_s = timing_t'(taps_s[D-1]);

   // RGB capture; blanking forces black regardless of returned colour
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_r <= 8'h00;
         g_r <= 8'h00;
         b_r <= 8'h00;
      end else if (mid_s.vis) begin
         r_r <= expand_bit(color[R_BIT]);
         g_r <= expand_bit(color[G_BIT]);
         b_r <= expand_bit(color[B_BIT]);
      end else begin
         r_r <= 8'h00;
         g_r <= 8'h00;
         b_r <= 8'h00;
      end
   end

   // frame pulse on the pixel step that wraps the raster back to (0,0)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= pix_en_r & hwrap_s & vwrap_s;
      end
   end

   assign vga_r       = r_r;
   assign vga_g       = g_r;
   assign vga_b       = b_r;
   assign vga_hs      = out_s.hs;
   assign vga_vs      = out_s.vs;
   assign vga_blank_n = out_s.vis;
   assign vga_sync_n  = 1'b0;
   assign vga_clk     = pix_en_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench: full-size instance for line timing, shrunken instance for frames.
// Expected pins are derived from the number of clk edges since reset release.
module tb_vga_scan_ctrl;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       blank_n;
      logic       sync_n;
      logic       vclk;
      logic       fs;
   } obs_t;

   typedef struct packed {
      int hv; int hfp; int hsw; int hbp;
      int vv; int vfp; int vsw; int vbp;
   } cfg_t;

   localparam cfg_t CFG0 = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam cfg_t CFG1 = '{40, 4, 8, 4, 20, 2, 2, 3};
   localparam obs_t RESET_OBS = '{x: 9'd0, y: 8'd0, r: 8'd0, g: 8'd0, b: 8'd0,
                                  hs: 1'b1, vs: 1'b1, blank_n: 1'b0, sync_n: 1'b0,
                                  vclk: 1'b0, fs: 1'b0};

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #10 clk = ~clk;

   logic [2:0] color0 = 3'd0, color1 = 3'd0;
   logic [8:0] x0, x1;
   logic [7:0] y0, y1, r0, g0, b0, r1, g1, b1;
   logic hs0, vs0, bn0, sn0, vc0, fs0, hs1, vs1, bn1, sn1, vc1, fs1;
   obs_t act0, act1;
   assign act0 = {x0, y0, r0, g0, b0, hs0, vs0, bn0, sn0, vc0, fs0};
   assign act1 = {x1, y1, r1, g1, b1, hs1, vs1, bn1, sn1, vc1, fs1};

   vga_scan_ctrl u_dut0 (
      .clk(clk), .resetn(resetn), .xvga(x0), .yvga(y0), .color(color0),
      .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0),
      .vga_blank_n(bn0), .vga_sync_n(sn0), .vga_clk(vc0), .frame_start(fs0));

   vga_scan_ctrl #(
      .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_VISIBLE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SPRITE_LATENCY(1)
   ) u_dut1 (
      .clk(clk), .resetn(resetn), .xvga(x1), .yvga(y1), .color(color1),
      .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
      .vga_blank_n(bn1), .vga_sync_n(sn1), .vga_clk(vc1), .frame_start(fs1));

   int tests = 0;
   int fails = 0;
   bit mode = 1'b0;
   int unsigned seed = 0;

   function automatic logic [2:0] spr(bit m, int unsigned s, int x, int y);
      int unsigned t;
      if (m) return 3'b111;
      if (x == 10) return 3'b101;
      t = x * 5 + y * 3 + s;
      return t[2:0];
   endfunction

   // Reference: after edge k the raster sits at physical pixel k/2; pins show pixel of edge k-2.
   function automatic obs_t ref_out(cfg_t c, int k, bit m, int unsigned s);
      obs_t o;
      int ht, vt, h, v, j, h2, v2;
      logic [2:0] col;
      bit vis, vis2;
      ht = c.hv + c.hfp + c.hsw + c.hbp;
      vt = c.vv + c.vfp + c.vsw + c.vbp;
      o = RESET_OBS;
      o.vclk = (k % 2 == 1);
      o.fs = (k > 0) && (k % (2 * ht * vt) == 0);
      h = (k / 2) % ht;
      v = (k / (2 * ht)) % vt;
      vis = (h < c.hv) && (v < c.vv);
      o.x = vis ? 9'(h / 2) : 9'd0;
      o.y = vis ? 8'(v / 2) : 8'd0;
      if (k >= 2) begin
         j = k - 2;
         h2 = (j / 2) % ht;
         v2 = (j / (2 * ht)) % vt;
         vis2 = (h2 < c.hv) && (v2 < c.vv);
         o.hs = !((h2 >= c.hv + c.hfp) && (h2 < c.hv + c.hfp + c.hsw));
         o.vs = !((v2 >= c.vv + c.vfp) && (v2 < c.vv + c.vfp + c.vsw));
         o.blank_n = vis2;
         col = spr(m, s, vis2 ? h2 / 2 : 0, vis2 ? v2 / 2 : 0);
         o.r = vis2 ? {8{col[2]}} : 8'h00;
         o.g = vis2 ? {8{col[1]}} : 8'h00;
         o.b = vis2 ? {8{col[0]}} : 8'h00;
      end
      return o;
   endfunction

   task automatic cmp_obs(string name, obs_t a, obs_t e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s t=%0t actual x=%0d y=%0d rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b vclk=%b fs=%b required x=%0d y=%0d rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b vclk=%b fs=%b",
                  name, $time, a.x, a.y, a.r, a.g, a.b, a.hs, a.vs, a.blank_n, a.sync_n, a.vclk, a.fs,
                  e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.blank_n, e.sync_n, e.vclk, e.fs);
      end
   endtask

   task automatic cmp_int(string name, int a, int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, a, e);
      end
   endtask

   // sprite stand-in: colour registered one clk after the coordinates
   initial forever begin
      @(posedge clk);
      color0 <= spr(mode, seed, int'(x0), int'(y0));
      color1 <= spr(mode, seed, int'(x1), int'(y1));
   end

   obs_t q0[$];
   obs_t q1[$];
   int k_edges = 0;

   // stimulus side of the scoreboard: push the expected pins for every edge
   initial forever begin
      @(posedge clk);
      if (!resetn) begin
         k_edges = 0;
         q0.push_back(RESET_OBS);
         q1.push_back(RESET_OBS);
      end else begin
         k_edges = k_edges + 1;
         q0.push_back(ref_out(CFG0, k_edges, mode, seed));
         q1.push_back(ref_out(CFG1, k_edges, mode, seed));
      end
   end

   int hs_run = 0, hs_seen = 0, hs_fall_cyc = -1, line_seen = 0;
   int vs_run = 0, vs_seen = 0, fs_last = -1, fs_seen = 0, cyc = 0;
   bit hs_ok = 1'b0, vs_ok = 1'b0;

   // monitor: pop and compare mid-cycle, plus pulse-width/period measurements
   initial forever begin
      obs_t e;
      @(negedge clk);
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp_obs("pins_full", act0, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         cmp_obs("pins_small", act1, e);
      end
      if (!resetn) begin
         hs_run = 0; vs_run = 0; hs_ok = 1'b0; vs_ok = 1'b0;
         hs_fall_cyc = -1; fs_last = -1; cyc = 0;
      end else begin
         cyc++;
         if (act0.hs == 1'b0) begin
            if (hs_run == 0 && hs_ok) begin
               if (hs_fall_cyc >= 0) begin
                  cmp_int("line_period", cyc - hs_fall_cyc, 1600);
                  line_seen++;
               end
               hs_fall_cyc = cyc;
            end
            hs_run++;
         end else begin
            if (hs_ok && hs_run > 0) begin
               cmp_int("hsync_width", hs_run, 192);
               hs_seen++;
            end
            hs_ok = 1'b1;
            hs_run = 0;
         end
         if (act1.vs == 1'b0) begin
            vs_run++;
         end else begin
            if (vs_ok && vs_run > 0) begin
               cmp_int("vsync_width", vs_run, 2 * 2 * 56);
               vs_seen++;
            end
            vs_ok = 1'b1;
            vs_run = 0;
         end
         if (act1.fs == 1'b1) begin
            if (fs_last >= 0) begin
               cmp_int("frame_period", cyc - fs_last, 2 * 56 * 27);
               fs_seen++;
            end
            fs_last = cyc;
         end
      end
   end

   initial begin
      seed = $urandom;
      mode = 1'b0;
      resetn = 1'b0;
      repeat (5) @(negedge clk);
      #2 resetn = 1'b1;
      // run to hcount=300 on the full-size raster, then reset asynchronously
      repeat (600) @(posedge clk);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      cmp_obs("async_reset_full", act0, RESET_OBS);
      cmp_obs("async_reset_small", act1, RESET_OBS);
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (6000 + $urandom_range(0, 1000)) @(posedge clk);
      // constant white sprite: blanking must still force black
      @(negedge clk);
      #2 resetn = 1'b0;
      mode = 1'b1;
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (7000) @(posedge clk);
      repeat (2) @(negedge clk);
      cmp_int("hsync_measured", int'(hs_seen > 0), 1);
      cmp_int("line_measured", int'(line_seen > 0), 1);
      cmp_int("vsync_measured", int'(vs_seen > 0), 1);
      cmp_int("frame_measured", int'(fs_seen > 0), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
